// File: rtl/alu_muldiv_pkg.sv
// Shared constants and types for the ALU control decoder and the iterative
// RV32M multiply/divide sequencer.
package alu_muldiv_pkg;

  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_I   = 3'b001;
  localparam logic [2:0] ALUOP_BR  = 3'b010;
  localparam logic [2:0] ALUOP_JMP = 3'b011;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  function automatic logic rs1_is_signed(input md_op_e op);
    return !(op == MD_MULHU || op == MD_DIVU || op == MD_REMU);
  endfunction

  function automatic logic rs2_is_signed(input md_op_e op);
    return (op == MD_MUL || op == MD_MULH || op == MD_DIV || op == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative sign-magnitude multiplier (shift-add) and restoring divider,
// one bit per cycle, with early completion for the RISC-V divide corner cases.
module muldiv_iter #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import alu_muldiv_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST_STEP = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state, state_next;
  logic [2:0]        op_q;
  logic              neg_q, neg_r;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [2*XLEN-1:0] acc;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   result_q;

  md_op_e          op_in;
  logic            is_div, div_off, a_neg, b_neg, div_zero, div_ovf;
  logic [XLEN-1:0] a_abs, b_abs;

  assign op_in    = md_op_e'(op);
  assign is_div   = op[2];
  assign div_off  = is_div && !ENABLE_DIV;
  assign a_neg    = rs1_is_signed(op_in) && rs1[XLEN-1];
  assign b_neg    = rs2_is_signed(op_in) && rs2[XLEN-1];
  assign a_abs    = a_neg ? -rs1 : rs1;
  assign b_abs    = b_neg ? -rs2 : rs2;
  assign div_zero = (rs2 == '0);
  assign div_ovf  = rs2_is_signed(op_in) && (rs1 == MIN_NEG) && (&rs2);

  // acc holds {partial product, multiplier} while multiplying and
  // {partial remainder, dividend/quotient} while dividing.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic [XLEN:0]     rem_sh;
  logic              rem_ge;
  logic [XLEN-1:0]   rem_diff;

  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign rem_ge   = (rem_sh >= {1'b0, b_mag});
  assign rem_diff = rem_sh[XLEN-1:0] - b_mag;
  assign div_next = {(rem_ge ? rem_diff : rem_sh[XLEN-1:0]), acc[XLEN-2:0], rem_ge};

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_val;

  always_comb begin
    prod_fix  = neg_q ? -acc : acc;
    quo_fix   = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix   = neg_r ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    final_val = '0;
    case (md_op_e'(op_q))
      MD_MUL:                        final_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  final_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:               final_val = quo_fix;
      default:                       final_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !div_off) begin
          busy = 1'b1;
          if (!is_div)                    state_next = ST_MUL;
          else if (div_zero || div_ovf)   state_next = ST_DONE;
          else                            state_next = ST_DIV;
        end
      end
      ST_MUL, ST_DIV: begin
        busy = 1'b1;
        if (flush)                   state_next = ST_IDLE;
        else if (count == LAST_STEP) state_next = ST_DONE;
      end
      default: begin
        done       = !flush;
        state_next = ST_IDLE;
      end
    endcase
  end

  // A flushed DONE shows the previously held result, so nothing leaks out.
  assign result = done ? final_val : result_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && div_off) begin
            result_q <= '0;
          end else if (start) begin
            op_q  <= op;
            count <= '0;
            a_mag <= a_abs;
            b_mag <= b_abs;
            if (!is_div) begin
              acc   <= {{XLEN{1'b0}}, b_abs};
              neg_q <= a_neg ^ b_neg;
              neg_r <= 1'b0;
            end else if (div_zero) begin
              acc   <= {rs1, {XLEN{1'b1}}};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else if (div_ovf) begin
              acc   <= {{XLEN{1'b0}}, rs1};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              acc   <= {{XLEN{1'b0}}, a_abs};
              neg_q <= a_neg ^ b_neg;
              neg_r <= a_neg;
            end
          end
        end
        ST_MUL: begin
          acc   <= mul_next;
          count <= count + 1'b1;
        end
        ST_DIV: begin
          acc   <= div_next;
          count <= count + 1'b1;
        end
        default: begin
          if (!flush) result_q <= final_val;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv_control.sv
// Execute-stage ALU control decoder with an attached iterative RV32M
// multiply/divide sequencer that stalls the pipeline while it works.
module alu_muldiv_control #(
  parameter int XLEN       = 32,
  parameter bit ENABLE_M   = 1'b1,
  parameter bit ENABLE_DIV = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [2:0]      ALU_Operation,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic [5:0]      ALU_Control,
  output logic            stall_o,
  output logic            md_done_o,
  output logic [XLEN-1:0] md_result_o
);
  import alu_muldiv_pkg::*;

  logic m_op, start;

  always_comb begin
    ALU_Control = 6'b000_000;
    if (ALU_Operation == ALUOP_JMP)
      ALU_Control = 6'b111_111;
    else if (ALU_Operation == ALUOP_BR)
      ALU_Control = {3'b010, func3};
    else if (ALU_Operation == ALUOP_R && func7 == F7_BASE)
      ALU_Control = {3'b000, func3};
    else if (ALU_Operation == ALUOP_R && func7 == F7_ALT)
      ALU_Control = {3'b001, func3};
    else if (ALU_Operation == ALUOP_I && func3 == 3'b101 && func7 == F7_ALT)
      ALU_Control = {3'b001, func3};
    else if (ALU_Operation == ALUOP_I)
      ALU_Control = {3'b000, func3};
    else if (ALU_Operation == ALUOP_R && func7 == F7_MULDIV && ENABLE_M)
      ALU_Control = {3'b011, func3};
  end

  assign m_op  = (ALU_Control[5:3] == 3'b011);
  assign start = valid_i && m_op && !flush_i;

  muldiv_iter #(
    .XLEN       (XLEN),
    .ENABLE_DIV (ENABLE_DIV)
  ) u_muldiv (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .flush  (flush_i),
    .op     (func3),
    .rs1    (rs1_i),
    .rs2    (rs2_i),
    .busy   (stall_o),
    .done   (md_done_o),
    .result (md_result_o)
  );

endmodule
